// File: rtl/store_drain_buffer.sv
// In-order store buffer between the store queue and the cache/MMIO write ports.
// Same-word cacheable stores fold into the youngest entry; the head entry is never modified.
module store_drain_buffer #(
  parameter int DEPTH    = 4,
  parameter bit COALESCE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IN_valid,
  input  logic [31:0] IN_addr,
  input  logic [31:0] IN_data,
  input  logic [3:0]  IN_wmask,
  input  logic        IN_isMMIO,
  output logic        OUT_stall,
  output logic        OUT_empty,
  output logic        OUT_fenceDone,
  output logic        OUT_cacheReq,
  output logic [29:0] OUT_cacheAddr,
  output logic [31:0] OUT_cacheData,
  output logic [3:0]  OUT_cacheWmask,
  input  logic        IN_cacheAck,
  output logic        OUT_mmioReq,
  output logic [31:0] OUT_mmioAddr,
  output logic [31:0] OUT_mmioData,
  output logic [3:0]  OUT_mmioWmask,
  input  logic        IN_mmioAck
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  wmask;
    logic        is_mmio;
  } entry_t;

  entry_t          buf_q [DEPTH];
  entry_t          buf_d [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d, tail_idx;
  logic [CW-1:0]   count_q, count_d;
  logic            empty_q, empty_d;
  logic            fence_q, fence_d;

  entry_t head_e, tail_e, merged;
  logic   stall, accept, can_merge, merge, alloc;
  logic   head_vld, is_fence, cache_req, mmio_req, pop;
  logic   unused_addr_lsb;

  assign unused_addr_lsb = ^IN_addr[1:0];

  always_comb begin
    head_e    = buf_q[head_q];
    tail_idx  = tail_q - PW'(1);
    tail_e    = buf_q[tail_idx];
    stall     = (count_q == CW'(DEPTH));
    accept    = IN_valid && !stall;
    // Needs two entries so the merge target is never the locked head.
    can_merge = COALESCE && (count_q >= CW'(2)) &&
                !tail_e.is_mmio && (tail_e.wmask != 4'b0) &&
                !IN_isMMIO && (IN_wmask != 4'b0) &&
                (tail_e.addr == IN_addr[31:2]);
    merge     = accept && can_merge;
    alloc     = accept && !can_merge;

    head_vld  = (count_q != '0);
    is_fence  = (head_e.wmask == 4'b0);
    cache_req = head_vld && !is_fence && !head_e.is_mmio;
    mmio_req  = head_vld && !is_fence && head_e.is_mmio;
    pop       = head_vld && (is_fence || (cache_req && IN_cacheAck) ||
                             (mmio_req && IN_mmioAck));

    merged = tail_e;
    for (int b = 0; b < 4; b++)
      if (IN_wmask[b]) merged.data[8*b +: 8] = IN_data[8*b +: 8];
    merged.wmask = tail_e.wmask | IN_wmask;
  end

  always_comb begin
    buf_d = buf_q;
    if (alloc) buf_d[tail_q] = '{addr: IN_addr[31:2], data: IN_data,
                                 wmask: IN_wmask, is_mmio: IN_isMMIO};
    if (merge) buf_d[tail_idx] = merged;
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(alloc);
    count_d = count_q + CW'(alloc) - CW'(pop);
    empty_d = (count_d == '0);
    fence_d = pop && is_fence;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      fence_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      empty_q <= empty_d;
      fence_q <= fence_d;
    end
  end

  // Payload needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign OUT_stall      = stall;
  assign OUT_empty      = empty_q;
  assign OUT_fenceDone  = fence_q;
  assign OUT_cacheReq   = cache_req;
  assign OUT_cacheAddr  = head_e.addr;
  assign OUT_cacheData  = head_e.data;
  assign OUT_cacheWmask = head_e.wmask;
  assign OUT_mmioReq    = mmio_req;
  assign OUT_mmioAddr   = {head_e.addr, 2'b00};
  assign OUT_mmioData   = head_e.data;
  assign OUT_mmioWmask  = head_e.wmask;

endmodule

// File: tb/tb_store_drain_buffer.sv
// Bench for store_drain_buffer: a vector table, directed corner sequences and a
// randomized run, all cross-checked every cycle against a queue-based model.
module tb_store_drain_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_mmio = 1'b0, cack = 1'b0, mack = 1'b0;
  logic [31:0] in_addr = '0, in_data = '0;
  logic [3:0]  in_wmask = '0;
  logic        stall, empty, fence_done, creq, mreq;
  logic [29:0] caddr;
  logic [31:0] cdata, maddr, mdata;
  logic [3:0]  cwm, mwm;

  store_drain_buffer #(.DEPTH(DEPTH), .COALESCE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .IN_valid(in_valid), .IN_addr(in_addr), .IN_data(in_data),
    .IN_wmask(in_wmask), .IN_isMMIO(in_mmio),
    .OUT_stall(stall), .OUT_empty(empty), .OUT_fenceDone(fence_done),
    .OUT_cacheReq(creq), .OUT_cacheAddr(caddr), .OUT_cacheData(cdata),
    .OUT_cacheWmask(cwm), .IN_cacheAck(cack),
    .OUT_mmioReq(mreq), .OUT_mmioAddr(maddr), .OUT_mmioData(mdata),
    .OUT_mmioWmask(mwm), .IN_mmioAck(mack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  wm;
    logic        mmio;
  } ent_t;

  ent_t mq[$];
  logic m_fence = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, derived from the model queue.
  task automatic model_check();
    logic exp_c, exp_m;
    exp_c = 1'b0;
    exp_m = 1'b0;
    if (mq.size() > 0) begin
      exp_c = (mq[0].wm != 4'b0) && !mq[0].mmio;
      exp_m = (mq[0].wm != 4'b0) && mq[0].mmio;
    end
    chk("stall", 32'(stall), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("fenceDone", 32'(fence_done), 32'(m_fence));
    chk("cacheReq", 32'(creq), 32'(exp_c));
    chk("mmioReq", 32'(mreq), 32'(exp_m));
    if (exp_c) begin
      chk("cacheAddr", 32'(caddr), 32'(mq[0].addr));
      chk("cacheData", cdata, mq[0].data);
      chk("cacheWmask", 32'(cwm), 32'(mq[0].wm));
    end
    if (exp_m) begin
      chk("mmioAddr", maddr, {mq[0].addr, 2'b00});
      chk("mmioData", mdata, mq[0].data);
      chk("mmioWmask", 32'(mwm), 32'(mq[0].wm));
    end
  endtask

  // What the upcoming clock edge does to the buffer contents.
  task automatic model_update(input logic v, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m, input logic mm, input logic ca,
                              input logic ma, input logic r);
    ent_t t;
    bit   pop, fence;
    int   last;
    if (r) begin
      mq.delete();
      m_fence = 1'b0;
      return;
    end
    pop   = 0;
    fence = 0;
    if (mq.size() > 0) begin
      if (mq[0].wm == 4'b0) begin pop = 1; fence = 1; end
      else if (mq[0].mmio)  pop = ma;
      else                  pop = ca;
    end
    if (v && mq.size() < DEPTH) begin
      last = mq.size() - 1;
      if (mq.size() >= 2 && !mq[last].mmio && mq[last].wm != 4'b0 && !mm && m != 4'b0 &&
          mq[last].addr == a[31:2]) begin
        t = mq[last];
        for (int b = 0; b < 4; b++)
          if (m[b]) t.data[8*b +: 8] = d[8*b +: 8];
        t.wm = t.wm | m;
        mq[last] = t;
      end else begin
        t.addr = a[31:2]; t.data = d; t.wm = m; t.mmio = mm;
        mq.push_back(t);
      end
    end
    if (pop) void'(mq.pop_front());
    m_fence = fence;
  endtask

  // One cycle: drive after the edge, check at the falling edge, advance the model.
  task automatic tick(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic mm, input logic ca,
                      input logic ma, input logic r);
    @(posedge clk); #1;
    in_valid = v; in_addr = a; in_data = d; in_wmask = m; in_mmio = mm;
    cack = ca; mack = ma; rst = r;
    @(negedge clk);
    model_check();
    model_update(v, a, d, m, mm, ca, ma, r);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                    input logic mm);
    tick(1'b1, a, d, m, mm, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic ca, input logic ma);
    tick(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, ca, ma, 1'b0);
  endtask

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] d;
    logic        ca;
    logic        e_stall;
    logic        e_empty;
    logic        e_creq;
    logic [29:0] e_caddr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic        rv, rmm, rca, rma, rr, prev_v, prev_st, prev_r;
    logic [31:0] ra, rd;
    logic [3:0]  rm;

    // Four distinct words fill the buffer, then drain with ack every cycle.
    tbl[0] = '{1'b1, 32'h0000_0100, 32'hA0A0_A0A0, 1'b0, 1'b0, 1'b1, 1'b0, 30'h0};
    tbl[1] = '{1'b1, 32'h0000_0200, 32'hB1B1_B1B1, 1'b0, 1'b0, 1'b0, 1'b1, 30'h40};
    tbl[2] = '{1'b1, 32'h0000_0300, 32'hC2C2_C2C2, 1'b0, 1'b0, 1'b0, 1'b1, 30'h40};
    tbl[3] = '{1'b1, 32'h0000_0400, 32'hD3D3_D3D3, 1'b0, 1'b0, 1'b0, 1'b1, 30'h40};
    tbl[4] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 30'h40};
    tbl[5] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 30'h80};
    tbl[6] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 30'hC0};
    tbl[7] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 30'h100};
    tbl[8] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 30'h0};

    // Reset with a store held on the inputs.
    tick(1'b1, 32'h0000_5000, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 32'h0000_5000, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_creq", 32'(creq), 32'd0);
    chk("rst_mreq", 32'(mreq), 32'd0);
    st(32'h0000_5000, 32'h1234_5678, 4'hF, 1'b0);
    idle(1'b0, 1'b0);
    chk("post_rst_creq", 32'(creq), 32'd1);
    chk("post_rst_caddr", 32'(caddr), 32'h1400);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      tick(tbl[i].v, tbl[i].a, tbl[i].d, 4'hF, 1'b0, tbl[i].ca, 1'b0, 1'b0);
      chk("tbl_stall", 32'(stall), 32'(tbl[i].e_stall));
      chk("tbl_empty", 32'(empty), 32'(tbl[i].e_empty));
      chk("tbl_creq", 32'(creq), 32'(tbl[i].e_creq));
      if (tbl[i].e_creq) chk("tbl_caddr", 32'(caddr), 32'(tbl[i].e_caddr));
    end

    // Coalesce C into B (B is the tail, A is the locked head).
    st(32'h0000_1000, 32'h0000_BEEF, 4'b0011, 1'b0);
    st(32'h0000_1004, 32'h0000_AAAA, 4'b0011, 1'b0);
    st(32'h0000_1006, 32'hCAFE_0000, 4'b1100, 1'b0);
    idle(1'b1, 1'b0);
    chk("merge_w1_addr", 32'(caddr), 32'h400);
    chk("merge_w1_data", cdata, 32'h0000_BEEF);
    idle(1'b1, 1'b0);
    chk("merge_w2_addr", 32'(caddr), 32'h401);
    chk("merge_w2_data", cdata, 32'hCAFE_AAAA);
    chk("merge_w2_wmask", 32'(cwm), 32'hF);
    idle(1'b0, 1'b0);
    chk("merge_empty", 32'(empty), 32'd1);

    // Same word as the head: no merge, two writes.
    st(32'h0000_2000, 32'h0000_0011, 4'b0001, 1'b0);
    st(32'h0000_2000, 32'h0000_2200, 4'b0010, 1'b0);
    idle(1'b1, 1'b0);
    chk("lock_w1_wmask", 32'(cwm), 32'h1);
    idle(1'b1, 1'b0);
    chk("lock_w2_addr", 32'(caddr), 32'h800);
    chk("lock_w2_wmask", 32'(cwm), 32'h2);
    idle(1'b0, 1'b0);

    // MMIO, cacheable, fence retire in commit order.
    st(32'h8000_0010, 32'hDEAD_0001, 4'hF, 1'b1);
    st(32'h0000_3000, 32'h3333_3333, 4'hF, 1'b0);
    st(32'h0000_0000, 32'h0000_0000, 4'h0, 1'b0);
    idle(1'b0, 1'b0);
    chk("ord_mreq", 32'(mreq), 32'd1);
    chk("ord_maddr", maddr, 32'h8000_0010);
    chk("ord_creq_low", 32'(creq), 32'd0);
    idle(1'b0, 1'b1);
    idle(1'b1, 1'b0);
    chk("ord_creq", 32'(creq), 32'd1);
    chk("ord_caddr", 32'(caddr), 32'hC00);
    chk("ord_mreq_low", 32'(mreq), 32'd0);
    idle(1'b0, 1'b0);
    chk("ord_fence_early", 32'(fence_done), 32'd0);
    idle(1'b0, 1'b0);
    chk("ord_fence", 32'(fence_done), 32'd1);
    chk("ord_empty", 32'(empty), 32'd1);
    idle(1'b0, 1'b0);
    chk("ord_fence_pulse", 32'(fence_done), 32'd0);

    // Reset while an MMIO request is pending; a late ack must be harmless.
    st(32'h8000_0020, 32'h0000_0055, 4'hF, 1'b1);
    idle(1'b0, 1'b0);
    chk("rstm_mreq", 32'(mreq), 32'd1);
    tick(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b1);
    chk("rstm_mreq_drop", 32'(mreq), 32'd0);
    chk("rstm_empty", 32'(empty), 32'd1);
    idle(1'b0, 1'b0);
    chk("rstm_still_empty", 32'(empty), 32'd1);

    // Randomized traffic; a stalled uop stays on the inputs until taken.
    prev_v = 1'b0; prev_st = 1'b0; prev_r = 1'b0;
    rv = 1'b0; ra = '0; rd = '0; rm = '0; rmm = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!(prev_v && prev_st && !prev_r)) begin
        rv  = ($urandom_range(0, 9) < 6);
        ra  = 32'h0000_4000 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
        rd  = $urandom;
        rm  = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        rmm = ($urandom_range(0, 4) == 0);
      end
      rca = ($urandom_range(0, 9) < 4);
      rma = ($urandom_range(0, 9) < 4);
      rr  = ($urandom_range(0, 199) == 0);
      prev_st = (mq.size() == DEPTH);
      tick(rv, ra, rd, rm, rmm, rca, rma, rr);
      prev_v = rv;
      prev_r = rr;
    end
    for (int i = 0; i < 8; i++) idle(1'b1, 1'b1);
    chk("final_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
